// File: rtl/mac_unit_pkg.sv
// Shared definitions for the iterative multiply/accumulate unit:
// operation codes, op bit positions, FSM states and ready levels.
package mac_unit_pkg;

   // Operation bus: [0] signed, [1] accumulate, [2] subtract (only with [1])
   localparam int MAC_OP_W      = 3;
   localparam int MAC_OP_SIGNED = 0;
   localparam int MAC_OP_ACC    = 1;
   localparam int MAC_OP_SUB    = 2;

   localparam logic [MAC_OP_W-1:0] EXE_MAC_MULTU = 3'b000;
   localparam logic [MAC_OP_W-1:0] EXE_MAC_MULT  = 3'b001;
   localparam logic [MAC_OP_W-1:0] EXE_MAC_MADDU = 3'b010;
   localparam logic [MAC_OP_W-1:0] EXE_MAC_MADD  = 3'b011;
   localparam logic [MAC_OP_W-1:0] EXE_MAC_MSUBU = 3'b110;
   localparam logic [MAC_OP_W-1:0] EXE_MAC_MSUB  = 3'b111;

   localparam logic MAC_RESULT_READY     = 1'b1;
   localparam logic MAC_RESULT_NOT_READY = 1'b0;

   typedef enum logic [1:0] {
      MAC_IDLE = 2'd0,
      MAC_MUL  = 2'd1,
      MAC_ACC  = 2'd2,
      MAC_DONE = 2'd3
   } mac_state_e;

endpackage

// File: rtl/mac_step.sv
// One radix-2^BPC iteration: adds mcand * bits, shifted left by shamt,
// to the running partial product. Purely combinational.
module mac_step #(
   parameter int WIDTH = 32,
   parameter int BPC   = 2,
   parameter int SHW   = $clog2(2*WIDTH)
) (
   input  logic [2*WIDTH-1:0] prod_i,
   input  logic [WIDTH-1:0]   mcand_i,
   input  logic [BPC-1:0]     bits_i,
   input  logic [SHW-1:0]     shamt_i,
   output logic [2*WIDTH-1:0] prod_o
);

   logic [2*WIDTH-1:0] term;

   // Partial term is formed at full result width so the shift never truncates
   always_comb begin
      term   = ({{WIDTH{1'b0}}, mcand_i} * {{(2*WIDTH-BPC){1'b0}}, bits_i}) << shamt_i;
      prod_o = prod_i + term;
   end

endmodule

// File: rtl/mac_unit.sv
// Iterative MULT/MULTU/MADD/MADDU/MSUB/MSUBU unit with start/ready handshake.
// Handshake: start_i is raised and held by EX; the unit answers with ready_o
// and holds result_o until start_i falls; annul_i aborts from any state.
// Optional: MAC_EARLY_TERM_EN leaves MUL as soon as the remaining multiplier
// bits are all zero.
module mac_unit
   import mac_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BPC   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 annul_i,
   input  logic [MAC_OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic [2*WIDTH-1:0]   hilo_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output mac_state_e           dbg_state_o
);

   localparam int N   = WIDTH / BPC;
   localparam int CW  = $clog2(N + 1);
   localparam int SHW = $clog2(2*WIDTH);

   mac_state_e           state_q, state_d;
   logic                 acc_q, sub_q, sign_q;
   logic [WIDTH-1:0]     mcand_q, mplr_q;
   logic [2*WIDTH-1:0]   hilo_q, prod_q, result_q;
   logic [CW-1:0]        cnt_q;

   logic [WIDTH-1:0]     abs1, abs2;
   logic [2*WIDTH-1:0]   prod_next, signed_prod, acc_result;
   logic [SHW-1:0]       shamt;
   logic                 last_iter;
   logic                 accept;

   assign accept = start_i && !annul_i;

   // Operand magnitudes; the most negative value maps onto itself, which is exact unsigned
   always_comb begin
      abs1 = (op_i[MAC_OP_SIGNED] && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
      abs2 = (op_i[MAC_OP_SIGNED] && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
   end

   assign shamt = SHW'(cnt_q) * SHW'(BPC);

   mac_step #(
      .WIDTH (WIDTH),
      .BPC   (BPC),
      .SHW   (SHW)
   ) u_step (
      .prod_i  (prod_q),
      .mcand_i (mcand_q),
      .bits_i  (mplr_q[BPC-1:0]),
      .shamt_i (shamt),
      .prod_o  (prod_next)
   );

   // Apply the sign, then the optional accumulate/subtract against forwarded HI/LO
   always_comb begin
      signed_prod = sign_q ? -prod_q : prod_q;
      acc_result  = signed_prod;
      if (acc_q) begin
         acc_result = sub_q ? (hilo_q - signed_prod) : (hilo_q + signed_prod);
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= MAC_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic; annul overrides every transition
   always_comb begin
      state_d   = state_q;
      last_iter = (cnt_q == CW'(N - 1));
`ifdef MAC_EARLY_TERM_EN
      last_iter = last_iter || ((mplr_q >> BPC) == '0);
`endif
      case (state_q)
         MAC_IDLE: if (accept)    state_d = MAC_MUL;
         MAC_MUL:  if (last_iter) state_d = MAC_ACC;
         MAC_ACC:                 state_d = MAC_DONE;
         MAC_DONE: if (!start_i)  state_d = MAC_IDLE;
         default:                 state_d = MAC_IDLE;
      endcase
      if (annul_i) state_d = MAC_IDLE;
   end

   // Datapath registers: latch in IDLE, iterate in MUL, capture result in ACC
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q    <= 1'b0;
         sub_q    <= 1'b0;
         sign_q   <= 1'b0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         hilo_q   <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else if (!annul_i) begin
         case (state_q)
            MAC_IDLE: if (start_i) begin
               acc_q   <= op_i[MAC_OP_ACC];
               sub_q   <= op_i[MAC_OP_SUB];
               sign_q  <= op_i[MAC_OP_SIGNED] & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
               mcand_q <= abs1;
               mplr_q  <= abs2;
               hilo_q  <= hilo_i;
               prod_q  <= '0;
               cnt_q   <= '0;
            end
            MAC_MUL: begin
               prod_q <= prod_next;
               mplr_q <= mplr_q >> BPC;
               cnt_q  <= cnt_q + CW'(1);
            end
            MAC_ACC: result_q <= acc_result;
            default: ;
         endcase
      end
   end

   assign result_o    = result_q;
   assign ready_o     = (state_q == MAC_DONE) ? MAC_RESULT_READY : MAC_RESULT_NOT_READY;
   assign busy_o      = (state_q == MAC_MUL) || (state_q == MAC_ACC);
   assign dbg_state_o = state_q;

`ifndef SYNTHESIS
   // EX must keep start_i high while the unit is working unless it annuls
   a_start_held: assert property (@(posedge clk) disable iff (!rst)
      (busy_o && !annul_i) |-> start_i)
      else $error("mac_unit: start_i dropped during MUL/ACC without annul_i");
`endif

endmodule

// File: tb/tb_mac_unit.sv
// Testbench for mac_unit: directed vectors, randomized ops against a
// plain-arithmetic reference model, annul, reset and hold scenarios.
module tb_mac_unit;
   import mac_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        annul_i = 1'b0;
   logic [2:0]  op_i = '0;
   logic [31:0] opdata1_i = '0;
   logic [31:0] opdata2_i = '0;
   logic [63:0] hilo_i = '0;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;
   mac_state_e  dbg_state_o;

   int n_checks = 0;
   int n_pass   = 0;

   mac_unit #(.WIDTH(32), .BPC(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .annul_i     (annul_i),
      .op_i        (op_i),
      .opdata1_i   (opdata1_i),
      .opdata2_i   (opdata2_i),
      .hilo_i      (hilo_i),
      .result_o    (result_o),
      .ready_o     (ready_o),
      .busy_o      (busy_o),
      .dbg_state_o (dbg_state_o)
   );

   // Clock
   always #5 clk = ~clk;

   // Reference model: full-width integer product, then accumulate
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] h);
      logic [63:0] p;
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op[0]) p = 64'(sa * sb);
      else       p = {32'b0, a} * {32'b0, b};
      if (!op[1])     return p;
      else if (op[2]) return h - p;
      else            return h + p;
   endfunction

   // Expected edges from start to ready
   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef MAC_EARLY_TERM_EN
      logic [31:0] mag;
      int bits, iters;
      mag  = (op[0] && b[31]) ? -b : b;
      bits = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
      iters = (bits + 1) / 2;
      if (iters < 1) iters = 1;
      return iters + 2;
`else
      return 18;
`endif
   endfunction

   // Drivers
   task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] h);
      @(negedge clk);
      start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hilo_i = h;
   endtask

   task automatic wait_ready(output int lat);
      lat = 0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         lat++;
         #1;
         if (ready_o) break;
      end
   endtask

   task automatic end_op();
      @(negedge clk);
      start_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] h,
                            input logic [63:0] expv, input int elat);
      int lat;
      logic [63:0] res;
      start_op(op, a, b, h);
      wait_ready(lat);
      res = result_o;
      n_checks++;
      if (res !== expv) $display("FAIL %s result: got %h expected %h", name, res, expv);
      else n_pass++;
      n_checks++;
      if (lat != elat) $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
      else n_pass++;
      end_op();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      n_checks++;
      if (result_o !== 64'd0) $display("FAIL reset result: got %h expected 0", result_o);
      else n_pass++;
      n_checks++;
      if (ready_o !== 1'b0) $display("FAIL reset ready: got %b expected 0", ready_o);
      else n_pass++;
      n_checks++;
      if (busy_o !== 1'b0) $display("FAIL reset busy: got %b expected 0", busy_o);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_directed();
      run_check("mult_neg3x5", EXE_MAC_MULT, -32'sd3, 32'd5, 64'd0,
                64'hFFFFFFFF_FFFFFFF1, exp_lat(EXE_MAC_MULT, 32'd5));
      run_check("multu_max", EXE_MAC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0,
                64'hFFFFFFFE_00000001, exp_lat(EXE_MAC_MULTU, 32'hFFFFFFFF));
      run_check("mult_minneg", EXE_MAC_MULT, 32'h80000000, 32'h80000000, 64'd0,
                64'h40000000_00000000, exp_lat(EXE_MAC_MULT, 32'h80000000));
      run_check("madd", EXE_MAC_MADD, 32'd4, -32'sd2, 64'h10,
                64'h00000000_00000008, exp_lat(EXE_MAC_MADD, -32'sd2));
      run_check("msubu", EXE_MAC_MSUBU, 32'd1, 32'd1, 64'd0,
                64'hFFFFFFFF_FFFFFFFF, exp_lat(EXE_MAC_MSUBU, 32'd1));
      run_check("msub", EXE_MAC_MSUB, 32'hFFFFFFFF, 32'd1, 64'h1_00000000,
                64'h1_00000001, exp_lat(EXE_MAC_MSUB, 32'd1));
   endtask

   task automatic test_random();
      logic [2:0] ops [6];
      logic [31:0] corner [4];
      logic [2:0] op;
      logic [31:0] a, b;
      logic [63:0] h;
      ops = '{EXE_MAC_MULTU, EXE_MAC_MULT, EXE_MAC_MADDU, EXE_MAC_MADD, EXE_MAC_MSUBU, EXE_MAC_MSUB};
      corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 5)];
         a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
         h  = {$urandom, $urandom};
         run_check($sformatf("rand%0d", i), op, a, b, h, model(op, a, b, h), exp_lat(op, b));
      end
   endtask

   task automatic test_annul();
      logic seen_ready;
      start_op(EXE_MAC_MULT, 32'd123, 32'd456, 64'd0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1; start_i = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (busy_o !== 1'b0) $display("FAIL annul busy: got %b expected 0", busy_o);
      else n_pass++;
      @(negedge clk);
      annul_i = 1'b0;
      seen_ready = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (ready_o) seen_ready = 1'b1;
      end
      n_checks++;
      if (seen_ready !== 1'b0) $display("FAIL annul ready: got %b expected 0", seen_ready);
      else n_pass++;
      run_check("after_annul", EXE_MAC_MULTU, 32'd2, 32'd3, 64'd0, 64'd6, exp_lat(EXE_MAC_MULTU, 32'd3));
      // annul and start together in IDLE
      @(negedge clk);
      annul_i = 1'b1; start_i = 1'b1; op_i = EXE_MAC_MULT; opdata1_i = 32'd9; opdata2_i = 32'd9;
      @(posedge clk);
      #1;
      n_checks++;
      if (dbg_state_o !== MAC_IDLE) $display("FAIL annul_start state: got %0d expected %0d", dbg_state_o, MAC_IDLE);
      else n_pass++;
      n_checks++;
      if (busy_o !== 1'b0) $display("FAIL annul_start busy: got %b expected 0", busy_o);
      else n_pass++;
      @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      start_op(EXE_MAC_MULTU, 32'd11, 32'd13, 64'd0);
      repeat (6) @(posedge clk);
      #3;
      rst = 1'b0; start_i = 1'b0;
      #1;
      n_checks++;
      if (busy_o !== 1'b0) $display("FAIL rst_mid busy: got %b expected 0", busy_o);
      else n_pass++;
      n_checks++;
      if (ready_o !== 1'b0) $display("FAIL rst_mid ready: got %b expected 0", ready_o);
      else n_pass++;
      n_checks++;
      if (result_o !== 64'd0) $display("FAIL rst_mid result: got %h expected 0", result_o);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_check("after_reset", EXE_MAC_MULTU, 32'd7, 32'd7, 64'd0, 64'd49, exp_lat(EXE_MAC_MULTU, 32'd7));
   endtask

   task automatic test_hold();
      int lat;
      logic [63:0] first, expv;
      logic stable;
      expv = model(EXE_MAC_MADD, 32'hDEAD0001, 32'h0000BEEF, 64'h12345678_9ABCDEF0);
      start_op(EXE_MAC_MADD, 32'hDEAD0001, 32'h0000BEEF, 64'h12345678_9ABCDEF0);
      wait_ready(lat);
      first = result_o;
      n_checks++;
      if (first !== expv) $display("FAIL hold result: got %h expected %h", first, expv);
      else n_pass++;
      stable = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (result_o !== expv || ready_o !== 1'b1) stable = 1'b0;
      end
      n_checks++;
      if (stable !== 1'b1) $display("FAIL hold stable: got %b expected 1", stable);
      else n_pass++;
      end_op();
      n_checks++;
      if (ready_o !== 1'b0 || dbg_state_o !== MAC_IDLE)
         $display("FAIL hold release: got ready=%b state=%0d expected ready=0 state=%0d", ready_o, dbg_state_o, MAC_IDLE);
      else n_pass++;
   endtask

   task automatic test_early_term();
`ifdef MAC_EARLY_TERM_EN
      run_check("early_7x1", EXE_MAC_MULTU, 32'd7, 32'd1, 64'd0, 64'd7, 3);
      run_check("early_zero", EXE_MAC_MULTU, 32'd7, 32'd0, 64'd0, 64'd0, 3);
`else
      run_check("early_7x1", EXE_MAC_MULTU, 32'd7, 32'd1, 64'd0, 64'd7, 18);
      run_check("early_zero", EXE_MAC_MULTU, 32'd7, 32'd0, 64'd0, 64'd0, 18);
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_annul();
      test_reset_mid();
      test_hold();
      test_early_term();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global bound so the run always ends
   initial begin
      #2000000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
